// File: rtl/rgmii_rx_ddr_capture_if.sv
// Bus bundle for the RGMII receive capture stage.
//   d_in : DDR pin data from the PHY (rxd[3:0], rx_ctl in bit 4)
//   q1   : rising-edge sample, presented on the rising edge
//   q2   : falling-edge sample, presented on the same rising edge as q1
// The pad side (master) drives d_in and consumes q1/q2.
// The capture stage (slave) does the opposite.
interface rgmii_rx_ddr_capture_if #(
    parameter int DATA_WIDTH = 5
);
    logic [DATA_WIDTH-1:0] d_in;
    logic [DATA_WIDTH-1:0] q1;
    logic [DATA_WIDTH-1:0] q2;

    modport master (output d_in, input  q1, q2);
    modport slave  (input  d_in, output q1, q2);
endinterface

// File: rtl/rgmii_rx_ddr_capture.sv
// RGMII receive DDR input capture (same-edge pipelined).
// d_in is sampled on both edges of the PHY rx clock. Both samples are then
// re-registered on the rising edge, so that q1/q2 change together and
// describe the same clock period.
// Ports:
//   clk   : PHY rx clock; this is the only clock
//   rst   : synchronous, active-high reset
//   o_clk : forwarded clock to the MAC, equal to clk, never gated
//   rx    : slave modport carrying d_in, q1 and q2
module rgmii_rx_ddr_capture #(
    parameter int   DATA_WIDTH = 5,
    parameter logic INIT_Q1    = 1'b0,
    parameter logic INIT_Q2    = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   o_clk,
    rgmii_rx_ddr_capture_if.slave  rx
);
    localparam logic [DATA_WIDTH-1:0] INIT1 = {DATA_WIDTH{INIT_Q1}};
    localparam logic [DATA_WIDTH-1:0] INIT2 = {DATA_WIDTH{INIT_Q2}};

    // Declaration initialisers give the power-up state. They apply before
    // any reset, which matches the FPGA primitive's INIT attributes.
    logic [DATA_WIDTH-1:0] rise_q = INIT1;
    logic [DATA_WIDTH-1:0] fall_q = INIT2;
    logic [DATA_WIDTH-1:0] q1_q   = INIT1;
    logic [DATA_WIDTH-1:0] q2_q   = INIT2;
    logic [DATA_WIDTH-1:0] rise_d, fall_d, q1_d, q2_d;

    // Divide bypass: the MAC runs directly from the PHY clock.
    assign o_clk = clk;

    always_comb begin
        rise_d = rx.d_in;
        fall_d = rx.d_in;
        q1_d   = rise_q;
        q2_d   = fall_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= INIT1;
            q1_q   <= INIT1;
            q2_q   <= INIT2;
        end else begin
            rise_q <= rise_d;
            q1_q   <= q1_d;
            q2_q   <= q2_d;
        end
    end

    // Falling-edge sample. Its reset is seen on the falling edge, so a reset
    // held across a full period also clears the half-period data path.
    always_ff @(negedge clk) begin
        if (rst) fall_q <= INIT2;
        else     fall_q <= fall_d;
    end

    assign rx.q1 = q1_q;
    assign rx.q2 = q2_q;
endmodule

// File: tb/tb_rgmii_rx_ddr_capture.sv
// Directed bench for rgmii_rx_ddr_capture.
// Two DUTs share clk, rst and d_in: one with INIT 0 and one with INIT 1.
module tb_rgmii_rx_ddr_capture;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic o_clk0, o_clk1;
    int   checks = 0;
    int   errors = 0;

    rgmii_rx_ddr_capture_if #(.DATA_WIDTH(5)) bus0 ();
    rgmii_rx_ddr_capture_if #(.DATA_WIDTH(5)) bus1 ();
    assign bus1.d_in = bus0.d_in;

    rgmii_rx_ddr_capture #(.DATA_WIDTH(5), .INIT_Q1(1'b0), .INIT_Q2(1'b0)) dut0 (
        .clk(clk), .rst(rst), .o_clk(o_clk0), .rx(bus0));
    rgmii_rx_ddr_capture #(.DATA_WIDTH(5), .INIT_Q1(1'b1), .INIT_Q2(1'b1)) dut1 (
        .clk(clk), .rst(rst), .o_clk(o_clk1), .rx(bus1));

    always #5 clk = ~clk;

    // Scoreboard state for each DUT: the pending rise/fall samples.
    logic [4:0] m_rise [2] = '{5'h00, 5'h1F};
    logic [4:0] m_fall [2] = '{5'h00, 5'h1F};
    logic [4:0] init_v [2] = '{5'h00, 5'h1F};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one clock period. The call starts just after a falling edge.
    // d_in=r is presented for the rising edge and d_in=f for the falling edge.
    // Right after the rising edge the outputs are checked against the model,
    // when do_chk is set.
    task automatic cyc(input logic [4:0] r, input logic [4:0] f, input bit do_chk);
        logic [4:0] e1, e2;
        bus0.d_in = r;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            e1 = rst ? init_v[k] : m_rise[k];
            e2 = rst ? init_v[k] : m_fall[k];
            m_rise[k] = rst ? init_v[k] : r;
            if (do_chk) begin
                chk(k == 0 ? "q1_dut0" : "q1_dut1", k == 0 ? bus0.q1 : bus1.q1, e1);
                chk(k == 0 ? "q2_dut0" : "q2_dut1", k == 0 ? bus0.q2 : bus1.q2, e2);
            end
        end
        if (do_chk) chk("o_clk_hi", {o_clk1, o_clk0}, 2'b11);
        bus0.d_in = f;
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) m_fall[k] = rst ? init_v[k] : f;
        if (do_chk) chk("o_clk_lo", {o_clk1, o_clk0}, 2'b00);
    endtask

    initial begin
        bus0.d_in = 5'h00;
        #1;
        // Power-up: the INIT values hold before any edge and before any reset.
        chk("pwr_q1_0", bus0.q1, 5'h00);
        chk("pwr_q2_0", bus0.q2, 5'h00);
        chk("pwr_q1_1", bus1.q1, 5'h1F);
        chk("pwr_q2_1", bus1.q2, 5'h1F);
        chk("pwr_oclk", {o_clk1, o_clk0}, 2'b00);
        cyc(5'h00, 5'h00, 1);
        cyc(5'h00, 5'h00, 1);

        // Reset held for 2 cycles while d_in toggles on every edge.
        rst = 1'b1;
        cyc(5'h1F, 5'h00, 1);
        chk("rst_q1_0", bus0.q1, 5'h00);
        chk("rst_q1_1", bus1.q1, 5'h1F);
        cyc(5'h1F, 5'h00, 1);
        chk("rst_q2_0", bus0.q2, 5'h00);
        chk("rst_q2_1", bus1.q2, 5'h1F);
        rst = 1'b0;

        // Directed pair: rise=15, fall=0A. It appears after the next rising edge.
        cyc(5'h15, 5'h0A, 1);
        cyc(5'h00, 5'h00, 1);
        chk("dir_q1", bus0.q1, 5'h15);
        chk("dir_q2", bus0.q2, 5'h0A);
        chk("dir_q1_i1", bus1.q1, 5'h15);

        // RGMII byte A5 with rx_ctl=1: low nibble on the rising edge,
        // high nibble on the falling edge.
        cyc(5'h15, 5'h1A, 1);
        cyc(5'h15, 5'h1A, 1);
        chk("a5_lo_nib", bus0.q1[3:0], 4'h5);
        chk("a5_hi_nib", bus0.q2[3:0], 4'hA);
        chk("a5_ctl", {bus0.q1[4], bus0.q2[4]}, 2'b11);

        // Per-bit independence: a single bit set on each edge.
        cyc(5'h01, 5'h10, 1);
        cyc(5'h00, 5'h00, 1);
        chk("bit_q1", bus0.q1, 5'h01);
        chk("bit_q2", bus0.q2, 5'h10);

        // Random stream of 100 cycles, checked against the model.
        for (int i = 0; i < 100; i++)
            cyc(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1);

        // Reset asserted mid-stream for a single cycle.
        rst = 1'b1;
        cyc(5'h0F, 5'h11, 1);
        chk("mid_rst_0", {bus0.q1, bus0.q2}, 10'h000);
        chk("mid_rst_1", {bus1.q1, bus1.q2}, 10'h3FF);
        rst = 1'b0;
        // First edge with rst=0: rise_r still holds INIT. The data sampled
        // here emerges one rising edge later.
        cyc(5'h0C, 5'h03, 1);
        chk("resume_init_1", bus1.q1, 5'h1F);
        cyc(5'h00, 5'h00, 1);
        chk("resume_q1", bus0.q1, 5'h0C);
        chk("resume_q2", bus0.q2, 5'h03);
        chk("resume_q2_1", bus1.q2, 5'h03);
        cyc(5'h00, 5'h00, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
